// File: rtl/gdma_rd_engine.sv
// Purpose : GDMA read engine. Splits a byte range into AXI4 INCR read bursts
//           (at most 256 beats, never crossing a 4 KB page) and forwards the
//           returned R beats as an AXI-Stream toward the GTP transmit side.
// Latency : op_start -> arvalid 2 cycles; AR-to-AR min spacing 2 cycles;
//           R -> stream 0 cycles (combinational pass-through).
// Backpressure: tready drives rready in the same cycle; at most
//           MAX_OUTSTANDING bursts in flight, further ARs wait in HOLD.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start_addr, length         byte start address, size code (beats = length[31:2]+1)
//   op_start                   start pulse, accepted only while gdma_done=1
//   gdma_done, rd_err          idle/complete flag, sticky R-response error flag
//   gdma_ddr_ar*               AXI4 AR channel (master)
//   gdma_ddr_r*                AXI4 R channel (master side)
//   gdma2gtp_t*                AXI-Stream toward GTP transmit
//
// Build option: define GDMA_RD_RRESP_CHECK_EN to flag non-OKAY R responses on
// rd_err; without it rd_err is tied low and rresp is ignored.

module gdma_rd_engine #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [48:0] start_addr,
    input  logic [31:0] length,
    input  logic        op_start,
    output logic        gdma_done,
    output logic        rd_err,
    output logic [48:0] gdma_ddr_araddr,
    output logic [7:0]  gdma_ddr_arlen,
    output logic [2:0]  gdma_ddr_arsize,
    output logic [1:0]  gdma_ddr_arburst,
    output logic        gdma_ddr_arvalid,
    input  logic        gdma_ddr_arready,
    input  logic [31:0] gdma_ddr_rdata,
    input  logic [1:0]  gdma_ddr_rresp,
    input  logic        gdma_ddr_rlast,
    input  logic        gdma_ddr_rvalid,
    output logic        gdma_ddr_rready,
    output logic        gdma2gtp_tvalid,
    input  logic        gdma2gtp_tready,
    output logic [31:0] gdma2gtp_tdata,
    output logic        gdma2gtp_tlast
);

    typedef enum logic [1:0] {IDLE, CALC, ADDR, HOLD} state_t;

    localparam logic [3:0] OUTST_MAX = 4'(MAX_OUTSTANDING);

    state_t      state_q, state_d;
    logic [46:0] waddr_q, waddr_d;       // current word address
    logic [30:0] rem_q, rem_d;           // beats still to be requested
    logic [30:0] total_q, total_d;       // beats in the whole transfer
    logic [30:0] rcv_q, rcv_d;           // beats received so far
    logic [8:0]  beats_q, beats_d;       // size of the burst being issued
    logic [3:0]  outst_q, outst_d;       // bursts issued but not fully returned
    logic        addr_done_q, addr_done_d;
    logic        rx_all_q, rx_all_d;
    logic        done_q, done_d;
    logic        arvalid_q, arvalid_d;
    logic [48:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;

    logic        accept;
    logic        ar_hs;
    logic        r_hs;
    logic        burst_ret;
    logic        room;
    logic        last_beat;
    logic [30:0] total_m1;
    logic [30:0] rem_after;
    logic [10:0] to_4k;
    logic [8:0]  cap;
    logic [8:0]  calc_beats;
    logic        unused_low;

    assign accept    = op_start && done_q;
    assign ar_hs     = arvalid_q && gdma_ddr_arready;
    assign r_hs      = gdma_ddr_rvalid && gdma2gtp_tready;
    // Guarded so stray rlast beats after a reset cannot underflow the count.
    assign burst_ret = r_hs && gdma_ddr_rlast && (outst_q != 4'd0);
    assign room      = outst_q < OUTST_MAX;
    assign total_m1  = total_q - 31'd1;
    assign last_beat = (rcv_q == total_m1);
    assign rem_after = rem_q - 31'(beats_q);

    // Words left before the next 4 KB boundary (1..1024), then clip to 256
    // and to what remains of the transfer.
    assign to_4k      = 11'd1024 - {1'b0, waddr_q[9:0]};
    assign cap        = (to_4k > 11'd256) ? 9'd256 : to_4k[8:0];
    assign calc_beats = (rem_q < {22'd0, cap}) ? rem_q[8:0] : cap;

    // Byte-lane bits of the address and size code carry no information.
    assign unused_low = ^{start_addr[1:0], length[1:0]};

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        rem_d       = rem_q;
        total_d     = total_q;
        rcv_d       = rcv_q;
        beats_d     = beats_q;
        outst_d     = outst_q;
        addr_done_d = addr_done_q;
        rx_all_d    = rx_all_q;
        done_d      = done_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = CALC;
                    waddr_d     = start_addr[48:2];
                    rem_d       = {1'b0, length[31:2]} + 31'd1;
                    total_d     = {1'b0, length[31:2]} + 31'd1;
                    rcv_d       = 31'd0;
                    rx_all_d    = 1'b0;
                    addr_done_d = 1'b0;
                    done_d      = 1'b0;
                end
            end
            CALC: begin
                beats_d  = calc_beats;
                araddr_d = {waddr_q, 2'b00};
                arlen_d  = 8'(calc_beats - 9'd1);
                if (room) begin
                    state_d   = ADDR;
                    arvalid_d = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (room) begin
                    state_d   = ADDR;
                    arvalid_d = 1'b1;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    waddr_d   = waddr_q + 47'(beats_q);
                    rem_d     = rem_after;
                    if (rem_after != 31'd0) begin
                        state_d = CALC;
                    end else begin
                        state_d     = IDLE;
                        addr_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case ({ar_hs, burst_ret})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase

        // Beats seen while idle are passed through but not counted.
        if (r_hs && !done_q) begin
            rcv_d = rcv_q + 31'd1;
            if (last_beat) begin
                rx_all_d = 1'b1;
            end
        end

        if (!done_q && addr_done_d && rx_all_d && (outst_d == 4'd0)) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            rem_q       <= '0;
            total_q     <= '0;
            rcv_q       <= '0;
            beats_q     <= '0;
            outst_q     <= '0;
            addr_done_q <= 1'b1;
            rx_all_q    <= 1'b1;
            done_q      <= 1'b1;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            rem_q       <= rem_d;
            total_q     <= total_d;
            rcv_q       <= rcv_d;
            beats_q     <= beats_d;
            outst_q     <= outst_d;
            addr_done_q <= addr_done_d;
            rx_all_q    <= rx_all_d;
            done_q      <= done_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
        end
    end

`ifdef GDMA_RD_RRESP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (r_hs && !done_q && (gdma_ddr_rresp != 2'b00)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rd_err = err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^gdma_ddr_rresp;
    assign rd_err       = 1'b0;
`endif

    assign gdma_done        = done_q;
    assign gdma_ddr_araddr  = araddr_q;
    assign gdma_ddr_arlen   = arlen_q;
    assign gdma_ddr_arsize  = 3'b010;
    assign gdma_ddr_arburst = 2'b01;
    assign gdma_ddr_arvalid = arvalid_q;

    assign gdma_ddr_rready  = gdma2gtp_tready;
    assign gdma2gtp_tvalid  = gdma_ddr_rvalid;
    assign gdma2gtp_tdata   = gdma_ddr_rdata;
    assign gdma2gtp_tlast   = !done_q && gdma_ddr_rvalid && last_beat;

endmodule

// File: tb/tb_gdma_rd_engine.sv
`timescale 1ns/1ps
module tb_gdma_rd_engine;
    localparam int MAXO = 2;
`ifdef GDMA_RD_RRESP_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [48:0] start_addr;
    logic [31:0] xfer_len;
    logic        op_start;
    logic        gdma_done, rd_err;
    logic [48:0] gdma_ddr_araddr;
    logic [7:0]  gdma_ddr_arlen;
    logic [2:0]  gdma_ddr_arsize;
    logic [1:0]  gdma_ddr_arburst;
    logic        gdma_ddr_arvalid, gdma_ddr_arready;
    logic [31:0] gdma_ddr_rdata;
    logic [1:0]  gdma_ddr_rresp;
    logic        gdma_ddr_rlast, gdma_ddr_rvalid, gdma_ddr_rready;
    logic        gdma2gtp_tvalid, gdma2gtp_tready;
    logic [31:0] gdma2gtp_tdata;
    logic        gdma2gtp_tlast;

    always #5 clk = ~clk;

    gdma_rd_engine #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .start_addr(start_addr), .length(xfer_len),
        .op_start(op_start), .gdma_done(gdma_done), .rd_err(rd_err),
        .gdma_ddr_araddr(gdma_ddr_araddr), .gdma_ddr_arlen(gdma_ddr_arlen),
        .gdma_ddr_arsize(gdma_ddr_arsize), .gdma_ddr_arburst(gdma_ddr_arburst),
        .gdma_ddr_arvalid(gdma_ddr_arvalid), .gdma_ddr_arready(gdma_ddr_arready),
        .gdma_ddr_rdata(gdma_ddr_rdata), .gdma_ddr_rresp(gdma_ddr_rresp),
        .gdma_ddr_rlast(gdma_ddr_rlast), .gdma_ddr_rvalid(gdma_ddr_rvalid),
        .gdma_ddr_rready(gdma_ddr_rready), .gdma2gtp_tvalid(gdma2gtp_tvalid),
        .gdma2gtp_tready(gdma2gtp_tready), .gdma2gtp_tdata(gdma2gtp_tdata),
        .gdma2gtp_tlast(gdma2gtp_tlast)
    );

    // Bench configuration (written by the main sequence only).
    bit          model_en   = 1'b1;
    int          resp_delay = 0;
    bit          r_gaps     = 1'b0;
    int          err_at     = -1;
    logic        man_rvalid = 1'b0, man_rlast = 1'b0;
    logic [31:0] man_rdata  = '0;

    // DDR slave model outputs and observations (written by the model only).
    logic        m_rvalid, m_rlast;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    int cyc = 0, n_ar = 0, n_rlast = 0, n_beats = 0;
    int mo = 0, max_mo = 0, hold_viol = 0, rready_viol = 0;
    logic [48:0] ar_addr_log [0:63];
    logic [7:0]  ar_len_log  [0:63];
    int          ar_cyc_log  [0:63];
    int          rl_cyc_log  [0:63];
    logic [31:0] beat_dat    [0:4095];
    logic        beat_last   [0:4095];

    assign gdma_ddr_rvalid = model_en ? m_rvalid : man_rvalid;
    assign gdma_ddr_rdata  = model_en ? m_rdata  : man_rdata;
    assign gdma_ddr_rlast  = model_en ? m_rlast  : man_rlast;
    assign gdma_ddr_rresp  = model_en ? m_rresp  : 2'b00;

    // DDR slave: samples handshakes on posedge, drives R on negedge.
    initial begin : ddr_model
        logic [48:0] q_addr [$];
        int          q_len  [$];
        int          q_cyc  [$];
        int          cur_left;
        logic [31:0] cur_addr;
        bit          ar_s, r_s;
        cur_left = 0; cur_addr = '0;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rresp = 2'b00;
        forever begin
            @(posedge clk);
            cyc++;
            ar_s = gdma_ddr_arvalid && gdma_ddr_arready;
            r_s  = gdma_ddr_rvalid && gdma_ddr_rready;
            if (gdma_ddr_rready !== gdma2gtp_tready) rready_viol++;
            if (gdma_ddr_arvalid && mo >= MAXO) hold_viol++;
            if (ar_s && n_ar < 64) begin
                ar_addr_log[n_ar] = gdma_ddr_araddr;
                ar_len_log[n_ar]  = gdma_ddr_arlen;
                ar_cyc_log[n_ar]  = cyc;
                n_ar++;
                q_addr.push_back(gdma_ddr_araddr);
                q_len.push_back(int'(gdma_ddr_arlen) + 1);
                q_cyc.push_back(cyc);
                mo++;
            end
            if (r_s && model_en && gdma_ddr_rlast && mo > 0) begin
                if (n_rlast < 64) rl_cyc_log[n_rlast] = cyc;
                n_rlast++;
                mo--;
            end
            if (gdma2gtp_tvalid && gdma2gtp_tready && n_beats < 4096) begin
                beat_dat[n_beats]  = gdma2gtp_tdata;
                beat_last[n_beats] = gdma2gtp_tlast;
                n_beats++;
            end
            if (mo > max_mo) max_mo = mo;
            @(negedge clk);
            if (rst) begin
                q_addr.delete(); q_len.delete(); q_cyc.delete();
                cur_left = 0; mo = 0; m_rvalid = 1'b0; m_rlast = 1'b0;
            end else if (model_en) begin
                if (r_s && m_rvalid) begin
                    cur_left--;
                    cur_addr += 32'd4;
                end
                if (cur_left == 0 && q_addr.size() > 0 && cyc >= q_cyc[0] + resp_delay) begin
                    cur_addr = q_addr.pop_front()[31:0];
                    cur_left = q_len.pop_front();
                    void'(q_cyc.pop_front());
                    m_rvalid = 1'b0;
                end
                if (cur_left > 0) begin
                    if (!m_rvalid || r_s)
                        m_rvalid = r_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                end else begin
                    m_rvalid = 1'b0;
                end
                m_rdata = cur_addr;
                m_rlast = (cur_left == 1);
                m_rresp = (n_beats == err_at) ? 2'b10 : 2'b00;
            end
        end
    end

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [48:0] a, input logic [31:0] l);
        @(negedge clk);
        start_addr = a; xfer_len = l; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
    endtask

    // Runs until done and all expected beats seen, optionally toggling tready
    // and pulsing op_start at iteration `poke`.
    task automatic wait_done(input string tag, input int base, input int cnt,
                             input bit rnd, input int poke);
        int n = 0;
        while (n < 4000 && !(gdma_done && (n_beats - base) >= cnt)) begin
            @(negedge clk);
            if (rnd) gdma2gtp_tready = 1'($urandom_range(0, 1));
            op_start = (n == poke);
            #1;
            n++;
        end
        op_start = 1'b0;
        gdma2gtp_tready = 1'b1;
        chk({tag, " completes in budget"}, 64'(n < 4000), 64'd1);
    endtask

    task automatic check_beats(input string tag, input int base, input int cnt,
                               input logic [31:0] a0);
        int derr = 0, nlast = 0;
        chk({tag, " beat count"}, 64'(n_beats - base), 64'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (beat_dat[base + i] !== a0 + 32'(4 * i)) derr++;
            if (beat_last[base + i] === 1'b1) nlast++;
        end
        chk({tag, " data errors"}, 64'(derr), 64'd0);
        chk({tag, " tlast count"}, 64'(nlast), 64'd1);
        chk({tag, " tlast on final"}, 64'(beat_last[base + cnt - 1]), 64'd1);
    endtask

    initial begin : main
        int ba, bb, br;
        rst = 1'b1; op_start = 1'b0; start_addr = '0; xfer_len = '0;
        gdma_ddr_arready = 1'b1; gdma2gtp_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset done",    64'(gdma_done), 64'd1);
        chk("reset rd_err",  64'(rd_err), 64'd0);
        chk("reset arvalid", 64'(gdma_ddr_arvalid), 64'd0);
        chk("reset araddr",  64'(gdma_ddr_araddr), 64'd0);
        chk("reset arlen",   64'(gdma_ddr_arlen), 64'd0);
        chk("arsize",        64'(gdma_ddr_arsize), 64'd2);
        chk("arburst",       64'(gdma_ddr_arburst), 64'd1);
        rst = 1'b0;

        // 1: single 4-beat burst, start-to-arvalid timing
        ba = n_ar; bb = n_beats;
        start_xfer(49'h100, 32'hC);
        #1;
        chk("t1 done cleared", 64'(gdma_done), 64'd0);
        chk("t1 arvalid N+1",  64'(gdma_ddr_arvalid), 64'd0);
        @(negedge clk); #1;
        chk("t1 arvalid N+2",  64'(gdma_ddr_arvalid), 64'd1);
        chk("t1 araddr",       64'(gdma_ddr_araddr), 64'h100);
        chk("t1 arlen",        64'(gdma_ddr_arlen), 64'd3);
        wait_done("t1", bb, 4, 1'b0, -1);
        chk("t1 ar count", 64'(n_ar - ba), 64'd1);
        check_beats("t1", bb, 4, 32'h100);
        chk("t1 done", 64'(gdma_done), 64'd1);

        // 2: 4 KB boundary split
        ba = n_ar; bb = n_beats;
        start_xfer(49'hFF8, 32'hC);
        wait_done("t2", bb, 4, 1'b0, -1);
        chk("t2 ar count", 64'(n_ar - ba), 64'd2);
        chk("t2 ar0 addr", 64'(ar_addr_log[ba]), 64'hFF8);
        chk("t2 ar0 len",  64'(ar_len_log[ba]), 64'd1);
        chk("t2 ar1 addr", 64'(ar_addr_log[ba + 1]), 64'h1000);
        chk("t2 ar1 len",  64'(ar_len_log[ba + 1]), 64'd1);
        chk("t2 ar spacing", 64'(ar_cyc_log[ba + 1] - ar_cyc_log[ba]), 64'd2);
        check_beats("t2", bb, 4, 32'hFF8);

        // 3: 1024 beats, delayed responses, outstanding limit of 2
        ba = n_ar; bb = n_beats; br = n_rlast;
        resp_delay = 20;
        start_xfer(49'h0, 32'hFFF);
        wait_done("t3", bb, 1024, 1'b0, -1);
        resp_delay = 0;
        chk("t3 ar count", 64'(n_ar - ba), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3 ar%0d addr", i), 64'(ar_addr_log[ba + i]), 64'(i * 32'h400));
            chk($sformatf("t3 ar%0d len", i),  64'(ar_len_log[ba + i]), 64'hFF);
        end
        check_beats("t3", bb, 1024, 32'h0);
        chk("t3 max outstanding", 64'(max_mo), 64'd2);
        chk("t3 ar while full", 64'(hold_viol), 64'd0);
        chk("t3 ar2 after first rlast",
            64'(ar_cyc_log[ba + 2] > rl_cyc_log[br]), 64'd1);

        // 4: random tready and R gaps, ignored second op_start
        ba = n_ar; bb = n_beats;
        r_gaps = 1'b1;
        start_xfer(49'h2000, 32'h7C);
        start_addr = 49'h5000; xfer_len = 32'h3C;
        wait_done("t4", bb, 32, 1'b1, 5);
        r_gaps = 1'b0;
        chk("t4 ar count", 64'(n_ar - ba), 64'd1);
        chk("t4 ar addr",  64'(ar_addr_log[ba]), 64'h2000);
        chk("t4 ar len",   64'(ar_len_log[ba]), 64'd31);
        check_beats("t4", bb, 32, 32'h2000);
        chk("t4 rready mirrors tready", 64'(rready_viol), 64'd0);

        // 5: error response on beat 2, cleared by next start
        bb = n_beats;
        err_at = n_beats + 1;
        start_xfer(49'h300, 32'hC);
        wait_done("t5", bb, 4, 1'b0, -1);
        err_at = -1;
        chk("t5 rd_err at done", 64'(rd_err), 64'(EXP_ERR));
        bb = n_beats;
        start_xfer(49'h400, 32'h4);
        #1;
        chk("t5 rd_err cleared", 64'(rd_err), 64'd0);
        wait_done("t5b", bb, 2, 1'b0, -1);
        check_beats("t5b", bb, 2, 32'h400);

        // 6: beats while idle pass through without tlast
        model_en = 1'b0;
        @(negedge clk);
        man_rvalid = 1'b1; man_rdata = 32'hDEADBEEF; man_rlast = 1'b1;
        #1;
        chk("t6 tvalid", 64'(gdma2gtp_tvalid), 64'd1);
        chk("t6 tdata",  64'(gdma2gtp_tdata), 64'hDEADBEEF);
        chk("t6 tlast",  64'(gdma2gtp_tlast), 64'd0);
        chk("t6 rready", 64'(gdma_ddr_rready), 64'd1);
        gdma2gtp_tready = 1'b0;
        #1;
        chk("t6 rready low", 64'(gdma_ddr_rready), 64'd0);
        gdma2gtp_tready = 1'b1;
        @(negedge clk);
        man_rvalid = 1'b0; man_rlast = 1'b0;
        #1;
        chk("t6 still done", 64'(gdma_done), 64'd1);
        model_en = 1'b1;

        // 7: reset while AR pending, then a clean transfer
        gdma_ddr_arready = 1'b0;
        start_xfer(49'h600, 32'h1C);
        repeat (2) @(negedge clk);
        #1;
        chk("t7 arvalid held", 64'(gdma_ddr_arvalid), 64'd1);
        chk("t7 araddr",       64'(gdma_ddr_araddr), 64'h600);
        chk("t7 arlen",        64'(gdma_ddr_arlen), 64'd7);
        rst = 1'b1;
        #1;
        chk("t7 rst done",    64'(gdma_done), 64'd1);
        chk("t7 rst arvalid", 64'(gdma_ddr_arvalid), 64'd0);
        chk("t7 rst araddr",  64'(gdma_ddr_araddr), 64'd0);
        chk("t7 rst arlen",   64'(gdma_ddr_arlen), 64'd0);
        @(negedge clk);
        rst = 1'b0; gdma_ddr_arready = 1'b1;
        bb = n_beats;
        start_xfer(49'h800, 32'h4);
        wait_done("t7b", bb, 2, 1'b0, -1);
        check_beats("t7b", bb, 2, 32'h800);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
